mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single Memory port (address/in/load, one-cycle read latency, busy) between two requesters: port A (CPU) and port B (program loader / debug bridge).
- Round-robin grant, optional B burst lock with bounded A starvation, busy-aware issue, and per-requester read-return tagging.
- Sits between CPU/loader and Memory in the top level.

Parameters:
- MAX_LOCK, 16, max consecutive B grants under b_lock while A waits before A is forced a grant.
- KBD_ADDR, 16'h6000, keyboard address; writes at or above it are suppressed.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  A access request, held until a_gnt
- a_we  in  1  A write enable
- a_addr  in  15  A word address
- a_wdata  in  16  A write data
- a_gnt  out  1  A request accepted this cycle
- a_rvalid  out  1  A read data valid
- a_rdata  out  16  A read data
- a_err  out  1  pulse: A write to read-only/unmapped address suppressed
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_err  same as A for port B
- b_lock  in  1  B requests burst lock
- mem_load  out  1  to Memory load
- mem_address  out  16  to Memory address, zero-extended from 15 bits
- mem_in  out  16  to Memory in
- mem_busy  in  1  from Memory busy
- mem_out  in  16  from Memory out

Behaviour:
- Reset (async, rst_n=0): a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, mem_load = 0; mem_address, mem_in = 0; last-winner = B (A wins first tie); lock counter = 0; state IDLE.
- Issue: combinational in the cycle of grant. mem_address/mem_in driven from the winner. mem_load = winner_we AND (addr < KBD_ADDR). At most one grant per cycle.
- No grant while mem_busy=1. Requests wait; req/addr/data must stay stable.
- Arbitration, no lock: single requester wins. Both requesting: winner is the port that did not win last; last-winner updates on every grant.
- States:
  - IDLE: no lock.
  - LOCKED: entered when B is granted with b_lock=1.
  - In LOCKED, B always wins over A and the lock counter increments for each B grant while a_req=1.
  - When the counter reaches MAX_LOCK, the next eligible grant goes to A and the counter clears. The state stays LOCKED.
  - Exit LOCKED to IDLE when b_lock=0 at a cycle with no B grant, or when b_req=0 and b_lock=0. The counter clears on exit.
- Read return:
  - Registered tag {owner, is_read} captured at grant.
  - The next cycle, owner_rvalid=1 and owner_rdata = mem_out (combinational pass-through). The other port's rdata holds its last value.
  - Writes produce no rvalid. Back-to-back reads give rvalid every cycle.
- Error: a write with addr >= KBD_ADDR is granted with mem_load=0, and x_err pulses 1 cycle in the cycle after grant. Reads of any address are allowed; mem_out is passed through unchanged.
- Grant with mem_busy rising in the same cycle: not possible. Grant is gated by the current mem_busy.
- Reset mid-read: the pending rvalid is dropped.

Decomposition:
- Shared package holds the memory map constants: RAM_TOP 16'h3FFF, SCREEN_BASE 16'h4000, KBD_ADDR 16'h6000, and the owner encoding (OWNER_A=0, OWNER_B=1).
- One sub-module, rr_pick2: a two-way round-robin picker with a force-A input. The state machine, lock counter and return tags stay in mem_arbiter.

Test Plan:
- A-only read addr 0x0010, RAM[0x10]=0x1234 -> a_gnt at cycle 0; a_rvalid=1, a_rdata=0x1234 at cycle 1; b_rvalid stays 0.
- a_req and b_req both asserted 4 cycles, reads, no lock -> grant order A,B,A,B; rvalid alternates with matching rdata.
- mem_busy=1 for 3 cycles with B write to 0x4000 pending -> no b_gnt, mem_load=0 during busy; b_gnt and mem_load=1 in the first cycle busy=0.
- b_lock=1, b_req continuous, a_req continuous, MAX_LOCK=16 -> 16 B grants then 1 A grant then B resumes; after b_lock drops, strict alternation.
- A write 0x6000 data 0xFFFF -> a_gnt=1, mem_load=0, a_err pulse next cycle, no a_rvalid.
- rst_n low in the cycle after an A read grant -> a_rvalid stays 0; all outputs 0; first post-reset tie grants A.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - memory map constants and shared arbiter types
package mem_arbiter_pkg;

  localparam logic [15:0] RAM_TOP     = 16'h3FFF;
  localparam logic [15:0] SCREEN_BASE = 16'h4000;
  localparam logic [15:0] KBD_ADDR    = 16'h6000;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } arb_state_t;

  // Captured at grant, consumed in the following cycle when read data returns.
  typedef struct packed {
    logic valid;
    logic owner;
    logic is_read;
    logic err;
  } ret_tag_t;

  function automatic logic is_writable(input logic [15:0] addr, input logic [15:0] kbd);
    return addr < kbd;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rtl/mem_arbiter_rr_pick2.sv - two-way round-robin picker with force-A and B-priority inputs
module rr_pick2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last_b,
  input  logic force_a,
  input  logic prio_b,
  output logic gnt_a,
  output logic gnt_b
);

  // Starvation relief outranks the burst lock, which outranks plain round-robin.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (req_a && req_b) begin
      if (force_a) begin
        gnt_a = 1'b1;
      end else if (prio_b) begin
        gnt_b = 1'b1;
      end else if (last_b) begin
        gnt_a = 1'b1;
      end else begin
        gnt_b = 1'b1;
      end
    end else begin
      gnt_a = req_a;
      gnt_b = req_b;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between CPU (A) and loader/debug (B)
module mem_arbiter #(
  parameter int          MAX_LOCK = 16,
  parameter logic [15:0] KBD_ADDR = mem_arbiter_pkg::KBD_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [14:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [15:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [14:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [15:0] b_rdata,
  output logic        b_err,
  input  logic        b_lock,
  output logic        mem_load,
  output logic [15:0] mem_address,
  output logic [15:0] mem_in,
  input  logic        mem_busy,
  input  logic [15:0] mem_out
);
  import mem_arbiter_pkg::*;

  localparam int CW = $clog2(MAX_LOCK + 1);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_b_q, last_b_d;
  ret_tag_t      tag_q, tag_d;
  logic [15:0]   a_rdata_q, a_rdata_d;
  logic [15:0]   b_rdata_q, b_rdata_d;

  logic        locked, force_a, pick_a, pick_b;
  logic        win_we, win_ok;
  logic [15:0] win_addr, win_wdata;

  assign locked  = (state_q == ST_LOCKED);
  assign force_a = locked && (cnt_q >= CW'(MAX_LOCK));

  rr_pick2 u_pick (
    .req_a   (a_req && !mem_busy),
    .req_b   (b_req && !mem_busy),
    .last_b  (last_b_q),
    .force_a (force_a),
    .prio_b  (locked && b_lock),
    .gnt_a   (pick_a),
    .gnt_b   (pick_b)
  );

  // Grants are combinational, so hold them off while reset is asserted.
  assign a_gnt = pick_a && rst_n;
  assign b_gnt = pick_b && rst_n;

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (a_gnt) begin
      win_we    = a_we;
      win_addr  = {1'b0, a_addr};
      win_wdata = a_wdata;
    end else if (b_gnt) begin
      win_we    = b_we;
      win_addr  = {1'b0, b_addr};
      win_wdata = b_wdata;
    end
    win_ok      = is_writable(win_addr, KBD_ADDR);
    mem_address = win_addr;
    mem_in      = win_wdata;
    mem_load    = win_we && win_ok;
  end

  always_comb begin
    tag_d.valid   = a_gnt || b_gnt;
    tag_d.owner   = b_gnt ? OWNER_B : OWNER_A;
    tag_d.is_read = !win_we;
    tag_d.err     = win_we && !win_ok;
  end

  assign a_rvalid = tag_q.valid && tag_q.is_read && (tag_q.owner == OWNER_A);
  assign b_rvalid = tag_q.valid && tag_q.is_read && (tag_q.owner == OWNER_B);
  assign a_err    = tag_q.valid && tag_q.err && (tag_q.owner == OWNER_A);
  assign b_err    = tag_q.valid && tag_q.err && (tag_q.owner == OWNER_B);
  assign a_rdata  = a_rvalid ? mem_out : a_rdata_q;
  assign b_rdata  = b_rvalid ? mem_out : b_rdata_q;
  assign a_rdata_d = a_rdata;
  assign b_rdata_d = b_rdata;

  always_comb begin
    last_b_d = last_b_q;
    if (b_gnt) begin
      last_b_d = 1'b1;
    end else if (a_gnt) begin
      last_b_d = 1'b0;
    end
  end

  // The counter tracks B grants taken while A is left waiting under the lock.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (b_gnt && b_lock) begin
          state_d = ST_LOCKED;
          cnt_d   = a_req ? CW'(1) : '0;
        end
      end
      ST_LOCKED: begin
        if (!b_gnt && !b_lock) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (a_gnt) begin
          cnt_d = '0;
        end else if (b_gnt && a_req && (cnt_q < CW'(MAX_LOCK))) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_b_q  <= 1'b1;
      tag_q     <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_b_q  <= last_b_d;
      tag_q     <= tag_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int MAX_LOCK = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [14:0] a_addr = '0;
  logic [15:0] a_wdata = '0;
  logic        b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
  logic [14:0] b_addr = '0;
  logic [15:0] b_wdata = '0;
  logic        mem_busy = 1'b0;
  logic [15:0] mem_out = '0;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err, mem_load;
  logic [15:0] a_rdata, b_rdata, mem_address, mem_in;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_LOCK(MAX_LOCK), .KBD_ADDR(16'h6000)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .b_lock(b_lock), .mem_load(mem_load), .mem_address(mem_address),
    .mem_in(mem_in), .mem_busy(mem_busy), .mem_out(mem_out)
  );

  // Memory responder with one-cycle read latency.
  logic [15:0] ram [0:32767] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (mem_load) ram[mem_address[14:0]] <= mem_in;
    mem_out <= ram[mem_address[14:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    b_lock = 0; mem_busy = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        a_req, a_we;
    logic [14:0] a_addr;
    logic [15:0] a_wdata;
    logic        b_req, b_we;
    logic [14:0] b_addr;
    logic [15:0] b_wdata;
    logic        busy;
    logic        e_ag, e_bg, e_load;
    logic [15:0] e_addr, e_in;
    logic        e_arv, e_brv, e_aerr, e_berr;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t tbl [13];

  // Random-phase reference model state.
  logic [15:0] sh [0:32767] = '{default: 16'h0000};
  bit          m_last_b, m_locked;
  int          m_cnt;
  bit          t_v, t_owner_b, t_rd, t_err;
  logic [15:0] t_data, m_rd_a, m_rd_b;

  function automatic logic [14:0] gen_addr();
    if ($urandom % 8 == 0) return 15'(32'h6000 + $urandom % 32'h2000);
    return 15'(32'h0100 + $urandom % 128);
  endfunction

  initial begin
    //            a_req we addr     wdata     b_req we addr     wdata    busy ag bg ld  addr       in        arv brv aerr berr rdata
    tbl[0]  = '{0, 0, 15'h0000, 16'h0000, 1, 1, 15'h0010, 16'h1234, 0, 0, 1, 1, 16'h0010, 16'h1234, 0, 0, 0, 0, 16'h0000};
    tbl[1]  = '{1, 0, 15'h0010, 16'h0000, 0, 0, 15'h0000, 16'h0000, 0, 1, 0, 0, 16'h0010, 16'h0000, 0, 0, 0, 0, 16'h0000};
    tbl[2]  = '{1, 0, 15'h0011, 16'h0000, 1, 0, 15'h0010, 16'h0000, 0, 0, 1, 0, 16'h0010, 16'h0000, 1, 0, 0, 0, 16'h1234};
    tbl[3]  = '{1, 0, 15'h0011, 16'h0000, 1, 0, 15'h0012, 16'h0000, 0, 1, 0, 0, 16'h0011, 16'h0000, 0, 1, 0, 0, 16'h1234};
    tbl[4]  = '{0, 0, 15'h0000, 16'h0000, 1, 1, 15'h4000, 16'hBEEF, 1, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h0000};
    tbl[5]  = '{0, 0, 15'h0000, 16'h0000, 1, 1, 15'h4000, 16'hBEEF, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000};
    tbl[6]  = '{0, 0, 15'h0000, 16'h0000, 1, 1, 15'h4000, 16'hBEEF, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000};
    tbl[7]  = '{0, 0, 15'h0000, 16'h0000, 1, 1, 15'h4000, 16'hBEEF, 0, 0, 1, 1, 16'h4000, 16'hBEEF, 0, 0, 0, 0, 16'h0000};
    tbl[8]  = '{0, 0, 15'h0000, 16'h0000, 1, 1, 15'h6000, 16'hFFFF, 0, 0, 1, 0, 16'h6000, 16'h0000, 0, 0, 0, 0, 16'h0000};
    tbl[9]  = '{1, 1, 15'h7FFF, 16'h5555, 0, 0, 15'h0000, 16'h0000, 0, 1, 0, 0, 16'h7FFF, 16'h0000, 0, 0, 0, 1, 16'h0000};
    tbl[10] = '{0, 0, 15'h0000, 16'h0000, 0, 0, 15'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0000};
    tbl[11] = '{1, 0, 15'h4000, 16'h0000, 0, 0, 15'h0000, 16'h0000, 0, 1, 0, 0, 16'h4000, 16'h0000, 0, 0, 0, 0, 16'h0000};
    tbl[12] = '{0, 0, 15'h0000, 16'h0000, 0, 0, 15'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'hBEEF};

    // Reset state
    idle_inputs();
    a_req = 1; b_req = 1;
    @(negedge clk);
    chk("rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
    chk("rst_rvalid", 32'({a_rvalid, b_rvalid, a_err, b_err}), 32'd0);
    chk("rst_mem", 32'({mem_load, mem_address, mem_in}), 32'd0);
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    do_reset();

    // Table vectors
    for (int i = 0; i < 13; i++) begin
      a_req = tbl[i].a_req; a_we = tbl[i].a_we; a_addr = tbl[i].a_addr; a_wdata = tbl[i].a_wdata;
      b_req = tbl[i].b_req; b_we = tbl[i].b_we; b_addr = tbl[i].b_addr; b_wdata = tbl[i].b_wdata;
      mem_busy = tbl[i].busy;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), 32'({a_gnt, b_gnt}), 32'({tbl[i].e_ag, tbl[i].e_bg}));
      chk($sformatf("v%0d_load", i), 32'(mem_load), 32'(tbl[i].e_load));
      if (tbl[i].e_ag || tbl[i].e_bg) chk($sformatf("v%0d_addr", i), 32'(mem_address), 32'(tbl[i].e_addr));
      if (tbl[i].e_load) chk($sformatf("v%0d_in", i), 32'(mem_in), 32'(tbl[i].e_in));
      chk($sformatf("v%0d_rvalid", i), 32'({a_rvalid, b_rvalid}), 32'({tbl[i].e_arv, tbl[i].e_brv}));
      chk($sformatf("v%0d_err", i), 32'({a_err, b_err}), 32'({tbl[i].e_aerr, tbl[i].e_berr}));
      if (tbl[i].e_arv) chk($sformatf("v%0d_a_rdata", i), 32'(a_rdata), 32'(tbl[i].e_rdata));
      if (tbl[i].e_brv) chk($sformatf("v%0d_b_rdata", i), 32'(b_rdata), 32'(tbl[i].e_rdata));
      @(posedge clk); #1;
    end

    // Burst lock with bounded A starvation, then alternation once the lock drops
    do_reset();
    a_req = 1; a_addr = 15'h0001; b_req = 1; b_addr = 15'h0002; b_lock = 1;
    for (int c = 0; c < 50; c++) begin
      bit exp_a;
      if (c == 40) b_lock = 0;
      exp_a = (c < 40) ? (c % 17 == 0) : ((c - 40) % 2 == 0);
      @(negedge clk);
      chk($sformatf("lock_c%0d", c), 32'({a_gnt, b_gnt}), exp_a ? 32'd2 : 32'd1);
      @(posedge clk); #1;
    end

    // Reset lands right after an A read grant
    do_reset();
    a_req = 1; a_addr = 15'h0010;
    @(negedge clk);
    chk("mid_rst_gnt", 32'(a_gnt), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    chk("mid_rst_outs", 32'({a_gnt, b_gnt, a_err, b_err, mem_load}), 32'd0);
    chk("mid_rst_bus", 32'({mem_address, mem_in}), 32'd0);
    chk("mid_rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    a_req = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rvalid", 32'(a_rvalid), 32'd0);
    @(posedge clk); #1;
    a_req = 1; b_req = 1; b_addr = 15'h0003;
    @(negedge clk);
    chk("post_rst_tie", 32'({a_gnt, b_gnt}), 32'd2);
    @(posedge clk); #1;

    // Randomized traffic against the reference model
    do_reset();
    m_last_b = 1; m_locked = 0; m_cnt = 0;
    t_v = 0; t_owner_b = 0; t_rd = 0; t_err = 0; t_data = '0;
    m_rd_a = '0; m_rd_b = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int          win;
      bit          ea, eb, w_we, exp_load;
      logic [15:0] w_addr, w_data;
      if (!a_req && $urandom % 100 < 50) begin
        a_req = 1; a_we = ($urandom % 3 == 0); a_addr = gen_addr(); a_wdata = 16'($urandom);
      end
      if (!b_req && $urandom % 100 < 50) begin
        b_req = 1; b_we = ($urandom % 3 == 0); b_addr = gen_addr(); b_wdata = 16'($urandom);
      end
      if ($urandom % 20 == 0) b_lock = ~b_lock;
      mem_busy = ($urandom % 5 == 0);

      ea = a_req && !mem_busy;
      eb = b_req && !mem_busy;
      win = 0;
      if (ea && eb) begin
        if (m_locked && m_cnt >= MAX_LOCK) win = 1;
        else if (m_locked && b_lock) win = 2;
        else win = m_last_b ? 1 : 2;
      end else if (ea) win = 1;
      else if (eb) win = 2;
      w_we   = (win == 1) ? a_we : (win == 2) ? b_we : 1'b0;
      w_addr = (win == 1) ? {1'b0, a_addr} : (win == 2) ? {1'b0, b_addr} : 16'h0;
      w_data = (win == 1) ? a_wdata : b_wdata;
      exp_load = (win != 0) && w_we && (w_addr < 16'h6000);
      if (t_v && t_rd && !t_owner_b) m_rd_a = t_data;
      if (t_v && t_rd && t_owner_b) m_rd_b = t_data;

      @(negedge clk);
      chk("rnd_gnt", 32'({a_gnt, b_gnt}), 32'({win == 1, win == 2}));
      chk("rnd_load", 32'(mem_load), 32'(exp_load));
      if (win != 0) chk("rnd_addr", 32'(mem_address), 32'(w_addr));
      if (exp_load) chk("rnd_in", 32'(mem_in), 32'(w_data));
      chk("rnd_rvalid", 32'({a_rvalid, b_rvalid}), 32'({t_v && t_rd && !t_owner_b, t_v && t_rd && t_owner_b}));
      chk("rnd_err", 32'({a_err, b_err}), 32'({t_v && t_err && !t_owner_b, t_v && t_err && t_owner_b}));
      chk("rnd_a_rdata", 32'(a_rdata), 32'(m_rd_a));
      chk("rnd_b_rdata", 32'(b_rdata), 32'(m_rd_b));

      @(posedge clk); #1;
      t_v = (win != 0);
      t_owner_b = (win == 2);
      t_rd = !w_we;
      t_err = w_we && (w_addr >= 16'h6000);
      t_data = sh[w_addr[14:0]];
      if (exp_load) sh[w_addr[14:0]] = w_data;
      if (!m_locked) begin
        if (win == 2 && b_lock) begin
          m_locked = 1;
          m_cnt = a_req ? 1 : 0;
        end
      end else if (win != 2 && !b_lock) begin
        m_locked = 0;
        m_cnt = 0;
      end else if (win == 1) begin
        m_cnt = 0;
      end else if (win == 2 && a_req) begin
        m_cnt++;
      end
      if (win != 0) m_last_b = (win == 2);
      if (win == 1) a_req = 0;
      if (win == 2) b_req = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
